alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing stage directly upstream of `alu`. It accepts 14-bit instructions over a valid/ready handshake and holds a 4-entry register file (R0..R3, WIDTH bits each). It drives `alu`'s A/B/opcode inputs from the register file, captures X/Y, writes results back, and presents each result on a valid/ready output port. It turns the combinational ALU into a programmable, self-contained execution unit.

## Interface
- `WIDTH`, 4, datapath width; must equal the `alu` operand width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  instruction accepted when both valid and ready are high at a rising edge.
- `instr`  in  14  instruction fields:
  - [13:10] opcode
  - [9:8] rd
  - [7:6] ra
  - [5:4] rb
  - [3:0] imm
- `alu_a`  out  WIDTH  to `alu` A.
- `alu_b`  out  WIDTH  to `alu` B.
- `alu_op`  out  4  to `alu` opcode.
- `alu_x`  in  WIDTH  from `alu` X (primary result).
- `alu_y`  in  WIDTH  from `alu` Y. Holds the product upper nibble for MUL and the remainder for DIV.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when both valid and ready are high at a rising edge.
- `res_x`  out  WIDTH  captured primary result.
- `res_y`  out  WIDTH  captured secondary result.
- `res_err`  out  1  instruction was illegal.
- `op_count`  out  8  count of completed result handshakes.

## Operation
- FSM states IDLE, EXEC, RESP.
  - IDLE: `instr_ready`=1. On accept, latch `instr` into the internal IR and go to EXEC.
  - EXEC: lasts exactly one cycle. Writeback and result capture happen at its closing edge, then go to RESP.
  - RESP: `res_valid`=1. When `res_ready`=1 at an edge, go to IDLE and increment `op_count`.
- ALU drive:
  - In EXEC only: `alu_a`=R[ra], `alu_b`=R[rb], `alu_op`=IR opcode.
  - In IDLE and RESP: all three ALU outputs are 0.
- Opcode classes:
  - 0000–1000 (AND, OR, NAND, NOR, XOR, XNOR, NOT A, ADD, SUB): R[rd]←`alu_x`, `res_x`←`alu_x`, `res_y`←`alu_y`.
  - 1001 MUL and 1010 DIV/MOD: R[rd]←`alu_x`, and R[(rd+1) mod 4]←`alu_y` on the same edge. rd=3 wraps so that Y is written to R0.
  - 1111 LDI: R[rd]←imm, `res_x`←imm, `res_y`←0. The ALU outputs are still 0 in this case (`alu_op` driven as 0000 is ignored).
  - 1011–1110 illegal: no register write, `res_x`=`res_y`=0, `res_err`=1.
- `res_err` is 0 for all legal opcodes.
- Arithmetic is modulo 2^WIDTH. The block does no arithmetic itself and performs no width extension.
- Register hazards:
  - Operands are read during EXEC, before the write edge, so ra==rd or rb==rd uses the old value.
  - The next instruction always observes completed writebacks.
- `res_x`, `res_y`, `res_err` hold their values from the EXEC capture until the next EXEC capture.
- `op_count` wraps 255→0.

## Timing
- Reset values:
  - State IDLE.
  - R0..R3 = 0.
  - `res_valid`=0, `res_x`=0, `res_y`=0, `res_err`=0, `op_count`=0.
  - `alu_a`, `alu_b`, `alu_op` = 0.
- `instr_ready` = (state==IDLE) & ~`rst`, so it is 0 while reset is asserted.
- Latency: accept at edge N → EXEC during cycle N..N+1 → `res_valid`=1 after edge N+1.
- Peak throughput is one instruction per 3 cycles, with `res_ready` held high.
- `instr_ready` is low in EXEC and RESP. `instr_valid` is ignored in those states, and the offered instruction must be held by the source.
- `res_valid` stays high with stable data until the handshake completes. It falls at the same edge as the handshake.
- The block presents no combinational path from `res_ready` to `instr_ready` within the same cycle; readiness returns on the edge after the result handshake.
- Reset mid-operation, asserted in EXEC or RESP:
  - Immediate return to IDLE.
  - The pending writeback is discarded.
  - `res_valid` drops asynchronously.
  - `op_count` is not incremented.

## Test plan
- Reset, then LDI R0←5, LDI R1←3, ADD rd=2 ra=0 rb=1 → ADD result `res_x`=8, R2=8, `op_count`=3, `res_err`=0.
- LDI R0←7, LDI R1←5, MUL rd=3 ra=0 rb=1 → `res_x`=3, `res_y`=2, R3=3, and R0=2 via wrap.
- LDI R0←13, LDI R1←4, DIV rd=1 ra=0 rb=1 → `res_x`=3, `res_y`=1, R1=3, R2=1. The operand read R1=4 (old value).
- Opcode 1100 → `res_err`=1, `res_x`=`res_y`=0, no register changes, `op_count` still increments.
- Hold `res_ready`=0 for 5 cycles after `res_valid` rises → `res_valid` and `res_x` are stable, `instr_ready`=0, and a new `instr_valid` is not accepted.
- Assert `rst` during EXEC of ADD rd=2 → R2 keeps 0, `res_valid`=0, `op_count`=0, `instr_ready`=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Instruction and result handshakes of the ALU issue controller.
//   Instruction port: instr_valid / instr_ready / instr[13:0]
//   Result port:      res_valid / res_ready / res_x / res_y / res_err
//   master : instruction source and result sink (drives instr, res_ready)
//   slave  : the issue controller (drives instr_ready and the result)
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             instr_valid;
    logic             instr_ready;
    logic [13:0]      instr;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_x;
    logic [WIDTH-1:0] res_y;
    logic             res_err;

    modport master (
        output instr_valid, instr, res_ready,
        input  instr_ready, res_valid, res_x, res_y, res_err
    );

    modport slave (
        input  instr_valid, instr, res_ready,
        output instr_ready, res_valid, res_x, res_y, res_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequencer in front of a combinational ALU. Accepts one instruction,
//   drives the ALU from a 4-entry register file for a single EXEC cycle,
//   writes back / captures the result, then holds it on the result port.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     bus (slave)     instruction and result handshakes
//     alu_a/b/op      ALU operand and opcode drive (zero outside EXEC)
//     alu_x/y         ALU primary / secondary result
//     op_count        completed result handshakes, wraps at 255
module alu_issue_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_ctrl_if.slave    bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_x,
    input  logic [WIDTH-1:0]   alu_y,
    output logic [7:0]         op_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_LAST_ALU = 4'b1000;
    localparam logic [3:0] OP_MUL      = 4'b1001;
    localparam logic [3:0] OP_DIV      = 4'b1010;
    localparam logic [3:0] OP_LDI      = 4'b1111;

    state_t           state_q, state_d;
    logic [13:0]      ir_q, ir_d;
    logic [WIDTH-1:0] regs_q [4];
    logic [WIDTH-1:0] regs_d [4];
    logic [WIDTH-1:0] res_x_q, res_x_d;
    logic [WIDTH-1:0] res_y_q, res_y_d;
    logic             res_err_q, res_err_d;
    logic [7:0]       op_count_q, op_count_d;

    logic [3:0]       ir_op;
    logic [1:0]       ir_rd, ir_ra, ir_rb, ir_rd_nxt;
    logic [WIDTH-1:0] ir_imm;

    assign ir_op     = ir_q[13:10];
    assign ir_rd     = ir_q[9:8];
    assign ir_ra     = ir_q[7:6];
    assign ir_rb     = ir_q[5:4];
    assign ir_rd_nxt = ir_rd + 2'd1;   // MUL/DIV secondary destination, wraps R3 -> R0
    assign ir_imm    = WIDTH'(ir_q[3:0]);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        regs_d     = regs_q;
        res_x_d    = res_x_q;
        res_y_d    = res_y_q;
        res_err_d  = res_err_q;
        op_count_d = op_count_q;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = '0;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Operands come from the pre-writeback register file, so
                // ra/rb aliasing rd always sees the old value.
                if (ir_op != OP_LDI) begin
                    alu_a  = regs_q[ir_ra];
                    alu_b  = regs_q[ir_rb];
                    alu_op = ir_op;
                end
                res_err_d = 1'b0;
                if (ir_op <= OP_LAST_ALU) begin
                    regs_d[ir_rd] = alu_x;
                    res_x_d       = alu_x;
                    res_y_d       = alu_y;
                end else if (ir_op == OP_MUL || ir_op == OP_DIV) begin
                    regs_d[ir_rd]     = alu_x;
                    regs_d[ir_rd_nxt] = alu_y;
                    res_x_d           = alu_x;
                    res_y_d           = alu_y;
                end else if (ir_op == OP_LDI) begin
                    regs_d[ir_rd] = ir_imm;
                    res_x_d       = ir_imm;
                    res_y_d       = '0;
                end else begin
                    res_x_d   = '0;
                    res_y_d   = '0;
                    res_err_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    state_d    = IDLE;
                    op_count_d = op_count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            res_x_q    <= '0;
            res_y_q    <= '0;
            res_err_q  <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            regs_q     <= regs_d;
            res_x_q    <= res_x_d;
            res_y_q    <= res_y_d;
            res_err_q  <= res_err_d;
            op_count_q <= op_count_d;
        end
    end

    // Ready is masked by rst so it is low for the whole reset pulse.
    assign bus.instr_ready = (state_q == IDLE) & ~rst;
    assign bus.res_valid   = (state_q == RESP);
    assign bus.res_x       = res_x_q;
    assign bus.res_y       = res_y_q;
    assign bus.res_err     = res_err_q;
    assign op_count        = op_count_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] alu_a, alu_b, alu_x, alu_y;
    logic [3:0]   alu_op;
    logic [7:0]   op_count;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(W)) bus ();

    alu_issue_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .op_count (op_count)
    );

    // Reference ALU: returns {y, x}. Illegal opcodes return all ones so a
    // missing zeroing of the result is visible.
    function automatic logic [2*W-1:0] alu_fn(input logic [3:0] op,
                                             input logic [W-1:0] a, b);
        logic [W-1:0]   x, y;
        logic [2*W-1:0] p;
        logic [W:0]     s;
        x = '0; y = '0;
        case (op)
            4'd0: x = a & b;
            4'd1: x = a | b;
            4'd2: x = ~(a & b);
            4'd3: x = ~(a | b);
            4'd4: x = a ^ b;
            4'd5: x = ~(a ^ b);
            4'd6: x = ~a;
            4'd7: begin s = {1'b0, a} + {1'b0, b}; x = s[W-1:0]; y = W'(s[W]); end
            4'd8: begin s = {1'b0, a} - {1'b0, b}; x = s[W-1:0]; y = W'(s[W]); end
            4'd9: begin p = a * b; x = p[W-1:0]; y = p[2*W-1:W]; end
            4'd10: begin
                if (b == 0) begin x = '1; y = a; end
                else begin x = a / b; y = a % b; end
            end
            default: begin x = '1; y = '1; end
        endcase
        return {y, x};
    endfunction

    assign {alu_y, alu_x} = alu_fn(alu_op, alu_a, alu_b);

    // Behavioural model: register file, handshake count, expected result
    // and which phase of a transaction the driver has put the DUT in.
    logic [W-1:0] mreg [4] = '{default: '0};
    int           mcount    = 0;
    logic [W-1:0] exp_x     = '0, exp_y = '0;
    logic         exp_err   = 1'b0;
    logic         exp_valid = 1'b0;
    logic         in_exec   = 1'b0;
    logic [W-1:0] last_x, last_y;
    logic         last_err;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        mcount = 0; exp_x = '0; exp_y = '0; exp_err = 1'b0;
        exp_valid = 1'b0; in_exec = 1'b0;
    endtask

    function automatic logic [13:0] enc(input logic [3:0] op, input logic [1:0] rd, ra, rb,
                                        input logic [3:0] imm);
        return {op, rd, ra, rb, imm};
    endfunction

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("instr_ready", bus.instr_ready, !rst && !in_exec && !exp_valid);
        chk("res_valid", bus.res_valid, exp_valid);
        chk("res_x", bus.res_x, exp_x);
        chk("res_y", bus.res_y, exp_y);
        chk("res_err", bus.res_err, exp_err);
        chk("op_count", op_count, 32'(mcount & 255));
        if (!in_exec) begin
            chk("alu_a_idle", alu_a, 0);
            chk("alu_b_idle", alu_b, 0);
            chk("alu_op_idle", alu_op, 0);
        end
    end

    // Issue one instruction, optionally stall the result for `hold` cycles
    // while offering another instruction, or reset during EXEC.
    task automatic issue(input logic [13:0] ins, input int hold, input bit rst_in_exec);
        logic [3:0]   op;
        logic [1:0]   rd, ra, rb;
        logic [2*W-1:0] r;
        int           waitc;
        op = ins[13:10]; rd = ins[9:8]; ra = ins[7:6]; rb = ins[5:4];
        @(negedge clk);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        waitc = 0;
        while (!bus.instr_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.instr_ready) begin
            chk("accept_timeout", 0, 1);
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        in_exec = 1'b1;
        @(negedge clk);
        chk("exec_alu_a", alu_a, (op == 4'hF) ? 0 : mreg[ra]);
        chk("exec_alu_b", alu_b, (op == 4'hF) ? 0 : mreg[rb]);
        chk("exec_alu_op", alu_op, (op == 4'hF) ? 0 : op);
        if (rst_in_exec) begin
            #2 rst = 1'b1;
            model_reset();
            @(negedge clk);
            #2 rst = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_exec = 1'b0;
        if (op <= 4'd10) begin
            r = alu_fn(op, mreg[ra], mreg[rb]);
            exp_x = r[W-1:0]; exp_y = r[2*W-1:W]; exp_err = 1'b0;
            mreg[rd] = exp_x;
            if (op >= 4'd9) mreg[rd + 2'd1] = exp_y;
        end else if (op == 4'hF) begin
            exp_x = W'(ins[3:0]); exp_y = '0; exp_err = 1'b0;
            mreg[rd] = exp_x;
        end else begin
            exp_x = '0; exp_y = '0; exp_err = 1'b1;
        end
        exp_valid = 1'b1;
        if (hold > 0) begin
            bus.instr = enc(4'd7, 2'd0, 2'd1, 2'd1, 4'd0);
            bus.instr_valid = 1'b1;
            repeat (hold) @(negedge clk);
        end
        @(negedge clk);
        last_x = bus.res_x; last_y = bus.res_y; last_err = bus.res_err;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        bus.instr_valid = 1'b0;
        exp_valid = 1'b0;
        mcount++;
    endtask

    // Read a register back through OR rd=r ra=r rb=r (rewrites the same value).
    task automatic rd_reg(input logic [1:0] r, input logic [W-1:0] req, input string nm);
        issue(enc(4'd1, r, r, r, 4'd0), 0, 1'b0);
        chk(nm, last_x, req);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.res_ready = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_instr_ready", bus.instr_ready, 0);
        chk("rst_op_count", op_count, 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // LDI / ADD
        issue(enc(4'hF, 2'd0, 2'd0, 2'd0, 4'd5), 0, 1'b0);
        issue(enc(4'hF, 2'd1, 2'd0, 2'd0, 4'd3), 0, 1'b0);
        issue(enc(4'd7, 2'd2, 2'd0, 2'd1, 4'd0), 0, 1'b0);
        chk("add_x", last_x, 8);
        chk("add_err", last_err, 0);
        chk("add_count", op_count, 3);
        rd_reg(2'd2, 4'd8, "add_r2");

        // MUL with rd=3 wrapping Y into R0
        issue(enc(4'hF, 2'd0, 2'd0, 2'd0, 4'd7), 0, 1'b0);
        issue(enc(4'hF, 2'd1, 2'd0, 2'd0, 4'd5), 0, 1'b0);
        issue(enc(4'd9, 2'd3, 2'd0, 2'd1, 4'd0), 0, 1'b0);
        chk("mul_x", last_x, 3);
        chk("mul_y", last_y, 2);
        rd_reg(2'd3, 4'd3, "mul_r3");
        rd_reg(2'd0, 4'd2, "mul_r0_wrap");

        // DIV with rb aliasing rd
        issue(enc(4'hF, 2'd0, 2'd0, 2'd0, 4'd13), 0, 1'b0);
        issue(enc(4'hF, 2'd1, 2'd0, 2'd0, 4'd4), 0, 1'b0);
        issue(enc(4'd10, 2'd1, 2'd0, 2'd1, 4'd0), 0, 1'b0);
        chk("div_x", last_x, 3);
        chk("div_y", last_y, 1);
        rd_reg(2'd1, 4'd3, "div_r1");
        rd_reg(2'd2, 4'd1, "div_r2");

        // Illegal opcode: error, zero result, no write
        issue(enc(4'b1100, 2'd0, 2'd1, 2'd2, 4'd9), 0, 1'b0);
        chk("ill_err", last_err, 1);
        chk("ill_x", last_x, 0);
        chk("ill_y", last_y, 0);
        rd_reg(2'd0, 4'd13, "ill_r0");

        // SUB with a 5-cycle result stall and a competing instruction offered
        issue(enc(4'd8, 2'd3, 2'd0, 2'd1, 4'd0), 5, 1'b0);
        chk("sub_x", last_x, 10);
        rd_reg(2'd0, 4'd13, "stall_r0");

        // XNOR R1=3, R2=1
        issue(enc(4'd5, 2'd0, 2'd1, 2'd2, 4'd0), 0, 1'b0);
        chk("xnor_x", last_x, 4'hD);

        // Reset during EXEC of ADD rd=2
        issue(enc(4'd7, 2'd2, 2'd0, 2'd1, 4'd0), 0, 1'b1);
        chk("rstx_count", op_count, 0);
        @(negedge clk);
        chk("rstx_ready", bus.instr_ready, 1);
        rd_reg(2'd2, 4'd0, "rstx_r2");

        // op_count wrap: 1 done, 255 more brings it to 0
        for (int i = 0; i < 255; i++)
            issue(enc(4'hF, 2'(i), 2'd0, 2'd0, 4'(i)), 0, 1'b0);
        @(negedge clk);
        chk("count_wrap", op_count, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
